fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single write port of the 8-bit FIFO1 buffer among NREQ producers.

---
 rtl/fifo_ctrl_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side controllers: FSM state encoding and
// a width helper.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } fifo_ctrl_state_t;

  // Returns the number of bits needed to index n items. The result is at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder. It returns the first set request at or after ptr,
// wrapping at NREQ.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr is always below NREQ, so a single subtraction wraps the sum back into range.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the FIFO1 write port, with a flush sequencer that drives the FIFO clear.
//  state    | meaning
//  ST_RUN   | arbitrate producers onto ENQ, accept flush requests
//  ST_FLUSH | hold fifo_clr for FLUSH_CYCLES cycles, block writes
//  ST_DONE  | one-cycle completion pulse, rotation pointer restarts at 0
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int WIDTH        = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  input  logic                     fifo_full,
  output logic [WIDTH-1:0]         fifo_d_in,
  output logic                     fifo_enq,
  output logic                     fifo_clr,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         enq_count
);

  localparam int IDX_W = clog2(NREQ);
  localparam int FC_W  = clog2(FLUSH_CYCLES + 1);

  fifo_ctrl_state_t state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] enq_count_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      rr_ptr_q    <= '0;
      enq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      if (fifo_enq) enq_count_q <= enq_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    fifo_enq    = 1'b0;
    fifo_clr    = 1'b0;
    flush_done  = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // A flush request takes priority over a grant that is ready in the same cycle.
        fifo_enq = pick_found && !fifo_full && !flush_req;
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else if (fifo_enq) begin
          rr_ptr_d = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      ST_FLUSH: begin
        fifo_clr = 1'b1;
        busy     = 1'b1;
        if (flush_cnt_q == '0) state_d = ST_DONE;
        else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
      ST_DONE: begin
        flush_done = 1'b1;
        busy       = 1'b1;
        rr_ptr_d   = '0;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The data mux returns zero when no write happens, so the FIFO input never sees X.
  always_comb begin
    req_ready = '0;
    fifo_d_in = '0;
    grant_id  = '0;
    if (fifo_enq) grant_id = pick_idx;
    for (int i = 0; i < NREQ; i++) begin
      if (fifo_enq && pick_idx == IDX_W'(i)) begin
        req_ready[i] = 1'b1;
        fifo_d_in    = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign enq_count = enq_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter. It checks the DUT against a queue-free
// behavioural model of the arbitration and flush rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  flush_req;
  logic                  flush_done;
  logic                  fifo_full;
  logic [WIDTH-1:0]      fifo_d_in;
  logic                  fifo_enq;
  logic                  fifo_clr;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [CNT_W-1:0]      enq_count;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit m_valid = 0;
  int m_ptr, m_count, m_flush_left;
  bit m_done;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush_req(flush_req), .flush_done(flush_done),
    .fifo_full(fifo_full), .fifo_d_in(fifo_d_in), .fifo_enq(fifo_enq),
    .fifo_clr(fifo_clr), .grant_id(grant_id), .busy(busy), .enq_count(enq_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(output bit found);
    found = 0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) begin
        found = 1;
        return i;
      end
    end
    return 0;
  endfunction

  function automatic bit model_run();
    return (m_flush_left == 0) && !m_done;
  endfunction

  task automatic compare_outputs();
    bit found, enq;
    int g;
    g = model_grant(found);
    enq = model_run() && found && !fifo_full && !flush_req;
    chk("fifo_enq", 32'(fifo_enq), 32'(enq));
    chk("grant_id", 32'(grant_id), enq ? g : 0);
    chk("req_ready", 32'(req_ready), enq ? (1 << g) : 0);
    chk("fifo_d_in", 32'(fifo_d_in), enq ? 32'(req_data[g*WIDTH +: WIDTH]) : 0);
    chk("fifo_clr", 32'(fifo_clr), 32'(m_flush_left > 0));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("busy", 32'(busy), 32'(!model_run()));
    chk("enq_count", 32'(enq_count), m_count);
  endtask

  task automatic model_edge();
    bit found, enq;
    int g;
    if (rst) begin
      m_valid = 1; m_ptr = 0; m_count = 0; m_flush_left = 0; m_done = 0;
      return;
    end
    g = model_grant(found);
    enq = model_run() && found && !fifo_full && !flush_req;
    if (m_done) begin
      m_done = 0;
      m_ptr = 0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_done = 1;
    end else if (flush_req) begin
      m_flush_left = FLUSH_CYCLES;
    end else if (enq) begin
      m_ptr = (g + 1) % NREQ;
      m_count = (m_count + 1) % (1 << CNT_W);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic full, input logic fl, input logic r);
    @(negedge clk);
    req_valid = v;
    fifo_full = full;
    flush_req = fl;
    rst = r;
    req_data = $urandom;
    #1;
    if (m_valid) compare_outputs();
    model_edge();
  endtask

  initial begin
    rst = 1; req_valid = '0; req_data = '0; flush_req = 0; fifo_full = 0;
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0);
    chk("reset_count", 32'(enq_count), 0);
    chk("reset_busy", 32'(busy), 0);

    // Test 1: all four requesters valid, so the grant rotates 0,1,2,3,...
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 0, 0, 0);
      chk("rr_seq", 32'(grant_id), i % 4);
    end
    step(4'b0000, 0, 0, 0);
    chk("count8", 32'(enq_count), 8);

    // Test 2: move the pointer to 2, then check the wrap back to 0 and the lone request 3.
    step(4'b0011, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    chk("wrap0", 32'(grant_id), 0);
    step(4'b0011, 0, 0, 0);
    chk("wrap1", 32'(grant_id), 1);
    step(4'b1000, 0, 0, 0);
    chk("only3", 32'(grant_id), 3);

    // Test 3: requester 2 waits while the FIFO is full.
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1, 0, 0);
      chk("full_noenq", 32'(fifo_enq), 0);
    end
    step(4'b0100, 0, 0, 0);
    chk("unfull_grant", 32'(grant_id), 2);

    // Test 4: a flush and a grant arrive together; the flush wins.
    step(4'b0001, 0, 1, 0);
    chk("flush_noenq", 32'(fifo_enq), 0);
    step(4'b0001, 0, 0, 0);
    step(4'b0001, 0, 0, 0);
    step(4'b0001, 0, 0, 0);
    chk("done_pulse", 32'(flush_done), 1);
    step(4'b0001, 0, 0, 0);
    chk("post_flush_grant", 32'(grant_id), 0);

    // Test 5: reset arrives in the first flush cycle.
    step(4'b0000, 0, 1, 0);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0);
    chk("abort_clr", 32'(fifo_clr), 0);
    chk("abort_done", 32'(flush_done), 0);
    chk("abort_count", 32'(enq_count), 0);

    // Test 6: the 4-bit enqueue counter wraps.
    for (int i = 0; i < 17; i++) step(4'b1111, 0, 0, 0);
    step(4'b0000, 0, 0, 0);
    chk("count_wrap", 32'(enq_count), 1);

    // Random stimulus.
    for (int i = 0; i < 400; i++)
      step(4'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 49) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
